// File: rtl/divsched.sv
// Two-port round-robin sequencer for the shared combinational 6-bit signed divider.
// Latches the granted operands, holds them for EXEC_CYCLES, then parks the result until taken.
module divsched #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [5:0] dividend0,
  input  logic [5:0] divisor0,
  output logic       ack0,
  output logic       valid0,
  output logic [5:0] quotient0,
  output logic [5:0] remainder0,
  output logic       err0,
  input  logic       taken0,
  input  logic       req1,
  input  logic [5:0] dividend1,
  input  logic [5:0] divisor1,
  output logic       ack1,
  output logic       valid1,
  output logic [5:0] quotient1,
  output logic [5:0] remainder1,
  output logic       err1,
  input  logic       taken1,
  output logic [5:0] div_dividend,
  output logic [5:0] div_divisor,
  input  logic [5:0] div_quotient,
  input  logic [5:0] div_remainder,
  input  logic       div_err,
  output logic       busy
);

  // state | meaning
  // IDLE  | waiting for a request; arbitration happens here
  // EXEC  | operands held on the divider, settle timer running
  // RESP  | result parked for the granted side until taken
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] EXEC_INIT = 4'(EXEC_CYCLES);

  state_t     state, state_nxt;
  logic       prio;
  logic       grant;
  logic [3:0] cnt;
  logic       do_grant;
  logic       grant_side;
  logic       do_capture;
  logic       do_release;

  always_comb begin
    state_nxt  = state;
    do_grant   = 1'b0;
    grant_side = grant;
    do_capture = 1'b0;
    do_release = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          do_grant   = 1'b1;
          // a lone req1 wins outright; a tie goes to the priority side
          grant_side = (req0 && req1) ? prio : req1;
          state_nxt  = EXEC;
        end
      end
      EXEC: begin
        if (cnt == 4'd1) begin
          do_capture = 1'b1;
          state_nxt  = RESP;
        end
      end
      RESP: begin
        if (grant ? taken1 : taken0) begin
          do_release = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      prio         <= 1'b0;
      grant        <= 1'b0;
      cnt          <= 4'd0;
      div_dividend <= 6'd0;
      div_divisor  <= 6'd0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      valid0       <= 1'b0;
      valid1       <= 1'b0;
      quotient0    <= 6'd0;
      remainder0   <= 6'd0;
      err0         <= 1'b0;
      quotient1    <= 6'd0;
      remainder1   <= 6'd0;
      err1         <= 1'b0;
    end else begin
      state <= state_nxt;
      ack0  <= do_grant && !grant_side;
      ack1  <= do_grant && grant_side;

      if (do_grant) begin
        grant        <= grant_side;
        div_dividend <= grant_side ? dividend1 : dividend0;
        div_divisor  <= grant_side ? divisor1 : divisor0;
        cnt          <= EXEC_INIT;
      end else if (state == EXEC) begin
        cnt <= cnt - 4'd1;
      end

      if (do_capture) begin
        if (grant) begin
          quotient1  <= div_quotient;
          remainder1 <= div_remainder;
          err1       <= div_err;
          valid1     <= 1'b1;
        end else begin
          quotient0  <= div_quotient;
          remainder0 <= div_remainder;
          err0       <= div_err;
          valid0     <= 1'b1;
        end
      end

      if (do_release) begin
        if (grant) valid1 <= 1'b0;
        else       valid0 <= 1'b0;
        prio <= ~grant;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_divsched.sv
// Directed bench for divsched: instance a runs with a one-cycle settle, instance b with three.
module tb_divsched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic       rst, req0, req1, taken0, taken1;
  logic [5:0] dividend0, divisor0, dividend1, divisor1;
  logic       ack0, ack1, valid0, valid1, err0, err1, busy;
  logic [5:0] quotient0, remainder0, quotient1, remainder1;
  logic [5:0] div_dividend, div_divisor, div_quotient, div_remainder;
  logic       div_err;

  logic       b_rst, b_req0, b_req1, b_taken0, b_taken1;
  logic [5:0] b_dividend0, b_divisor0, b_dividend1, b_divisor1;
  logic       b_ack0, b_ack1, b_valid0, b_valid1, b_err0, b_err1, b_busy;
  logic [5:0] b_quotient0, b_remainder0, b_quotient1, b_remainder1;
  logic [5:0] b_div_dividend, b_div_divisor, b_div_quotient, b_div_remainder;
  logic       b_div_err;

  // behavioural stand-in for the shared divider
  function automatic logic [12:0] divm(input logic [5:0] a, input logic [5:0] b);
    logic signed [5:0] sa, sb, q, r;
    sa = a;
    sb = b;
    if (b == 6'd0) return {6'h00, a, 1'b1};
    if (a == 6'h20 && b == 6'h3F) return {6'h20, 6'h00, 1'b1};
    q = sa / sb;
    r = sa % sb;
    return {q, r, 1'b0};
  endfunction

  always_comb {div_quotient, div_remainder, div_err} = divm(div_dividend, div_divisor);
  always_comb {b_div_quotient, b_div_remainder, b_div_err} = divm(b_div_dividend, b_div_divisor);

  divsched #(.EXEC_CYCLES(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .req0(req0), .dividend0(dividend0), .divisor0(divisor0), .ack0(ack0), .valid0(valid0),
    .quotient0(quotient0), .remainder0(remainder0), .err0(err0), .taken0(taken0),
    .req1(req1), .dividend1(dividend1), .divisor1(divisor1), .ack1(ack1), .valid1(valid1),
    .quotient1(quotient1), .remainder1(remainder1), .err1(err1), .taken1(taken1),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .div_err(div_err), .busy(busy)
  );

  divsched #(.EXEC_CYCLES(3)) u_dut_b (
    .clk(clk), .rst(b_rst),
    .req0(b_req0), .dividend0(b_dividend0), .divisor0(b_divisor0), .ack0(b_ack0), .valid0(b_valid0),
    .quotient0(b_quotient0), .remainder0(b_remainder0), .err0(b_err0), .taken0(b_taken0),
    .req1(b_req1), .dividend1(b_dividend1), .divisor1(b_divisor1), .ack1(b_ack1), .valid1(b_valid1),
    .quotient1(b_quotient1), .remainder1(b_remainder1), .err1(b_err1), .taken1(b_taken1),
    .div_dividend(b_div_dividend), .div_divisor(b_div_divisor), .div_quotient(b_div_quotient),
    .div_remainder(b_div_remainder), .div_err(b_div_err), .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; req0 = 0; req1 = 0; taken0 = 0; taken1 = 0;
    dividend0 = 0; divisor0 = 0; dividend1 = 0; divisor1 = 0;
    b_rst = 1'b1; b_req0 = 0; b_req1 = 0; b_taken0 = 0; b_taken1 = 0;
    b_dividend0 = 0; b_divisor0 = 0; b_dividend1 = 0; b_divisor1 = 0;
    @(negedge clk);
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", {valid1, valid0}, 0);
    chk("rst_ack", {ack1, ack0}, 0);
    chk("rst_ops", {div_dividend, div_divisor}, 0);
    chk("rst_res", {quotient0, remainder0}, 0);
    chk("rst_b_busy", b_busy, 0);
    rst = 1'b0;
    b_rst = 1'b0;

    // 13/4, settle 1, taken held high
    req0 = 1; dividend0 = 6'h0D; divisor0 = 6'h04; taken0 = 1;
    tick();
    chk("t1_ack", {ack1, ack0}, 2'b01);
    chk("t1_busy", busy, 1);
    chk("t1_valid_early", valid0, 0);
    chk("t1_ops", {div_dividend, div_divisor}, {6'h0D, 6'h04});
    req0 = 0;
    tick();
    chk("t1_ack_low", ack0, 0);
    chk("t1_valid", valid0, 1);
    chk("t1_quot", quotient0, 6'h03);
    chk("t1_rem", remainder0, 6'h01);
    chk("t1_err", err0, 0);
    tick();
    chk("t1_valid_drop", valid0, 0);
    chk("t1_idle", busy, 0);
    taken0 = 0;

    // 5/0 with a long wait before taken
    req0 = 1; dividend0 = 6'h05; divisor0 = 6'h00;
    tick();
    chk("t3_ack", ack0, 1);
    req0 = 0;
    tick();
    chk("t3_valid", valid0, 1);
    chk("t3_err", err0, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("t3_hold%0d", i), {valid0, err0, busy}, 3'b111);
      chk($sformatf("t3_res%0d", i), {quotient0, remainder0}, {6'h00, 6'h05});
    end
    taken0 = 1;
    tick();
    chk("t3_release", {valid0, busy}, 0);
    taken0 = 0;

    // operand change after grant, stray taken1 during RESP
    req0 = 1; dividend0 = 6'h0D; divisor0 = 6'h04;
    tick();
    chk("t5_ack", ack0, 1);
    dividend0 = 6'h01; req0 = 0;
    chk("t5_ops", {div_dividend, div_divisor}, {6'h0D, 6'h04});
    tick();
    chk("t5_res", {valid0, quotient0, remainder0}, {1'b1, 6'h03, 6'h01});
    taken1 = 1;
    tick();
    chk("t5_taken1_ignored", {valid0, valid1, busy}, 3'b101);
    taken1 = 0; taken0 = 1;
    tick();
    chk("t5_release", {valid0, busy}, 0);
    taken0 = 0;

    // simultaneous requests after reset: port 0 first
    rst = 1;
    tick();
    rst = 0;
    req0 = 1; dividend0 = 6'h14; divisor0 = 6'h03;
    req1 = 1; dividend1 = 6'h09; divisor1 = 6'h02;
    tick();
    chk("t4_first", {ack1, ack0}, 2'b01);
    req0 = 0;
    tick();
    chk("t4_res0", {valid0, quotient0, remainder0}, {1'b1, 6'h06, 6'h02});
    chk("t4_v1_low", valid1, 0);
    taken0 = 1;
    tick();
    chk("t4_gap", {busy, ack1, valid0}, 0);
    taken0 = 0;
    tick();
    chk("t4_second", {ack1, ack0}, 2'b10);
    req1 = 0;
    tick();
    chk("t4_res1", {valid1, quotient1, remainder1}, {1'b1, 6'h04, 6'h01});
    chk("t4_res0_kept", {valid0, quotient0, remainder0}, {1'b0, 6'h06, 6'h02});
    taken1 = 1;
    tick();
    chk("t4_release", {valid1, busy}, 0);

    // continuous requests alternate strictly
    req0 = 1; req1 = 1; taken0 = 1; taken1 = 1;
    for (int g = 0; g < 8; g++) begin
      n = 0;
      while (!(ack0 || ack1) && n < 8) begin
        tick();
        n++;
      end
      chk($sformatf("alt_wait%0d", g), (n >= 8), 0);
      chk($sformatf("alt_grant%0d", g), {ack1, ack0}, (g % 2 == 1) ? 2'b10 : 2'b01);
      tick();
    end
    req0 = 0; req1 = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("alt_drain", busy, 0);
    taken0 = 0; taken1 = 0;

    // reset during EXEC drops the request
    req0 = 1; dividend0 = 6'h08; divisor0 = 6'h02;
    tick();
    chk("t6_ack", {ack0, busy}, 2'b11);
    rst = 1; req0 = 0;
    tick();
    chk("t6_rst", {busy, valid0, valid1, ack0, ack1}, 0);
    chk("t6_res_clear", {quotient0, remainder0}, 0);
    rst = 0;
    tick();
    chk("t6_no_stale", {busy, valid0, ack0}, 0);
    req0 = 1;
    tick();
    chk("t6_ack2", ack0, 1);
    req0 = 0;
    tick();
    chk("t6_res", {valid0, quotient0, remainder0, err0}, {1'b1, 6'h04, 6'h00, 1'b0});
    taken0 = 1;
    tick();
    taken0 = 0;
    chk("t6_release", {valid0, busy}, 0);

    // instance b: -13/4 with a three-cycle settle
    b_req1 = 1; b_dividend1 = 6'h33; b_divisor1 = 6'h04;
    tick();
    chk("t2_ack", {b_ack1, b_ack0}, 2'b10);
    chk("t2_ops0", {b_div_dividend, b_div_divisor}, {6'h33, 6'h04});
    b_req1 = 0; b_dividend1 = 6'h00; b_divisor1 = 6'h00;
    tick();
    chk("t2_e1", {b_valid1, b_ack1, b_busy}, 3'b001);
    chk("t2_ops1", {b_div_dividend, b_div_divisor}, {6'h33, 6'h04});
    tick();
    chk("t2_e2", {b_valid1, b_busy}, 2'b01);
    chk("t2_ops2", {b_div_dividend, b_div_divisor}, {6'h33, 6'h04});
    tick();
    chk("t2_valid", b_valid1, 1);
    chk("t2_res", {b_quotient1, b_remainder1, b_err1}, {6'h3D, 6'h3F, 1'b0});
    chk("t2_v0_low", b_valid0, 0);
    b_taken1 = 1;
    tick();
    chk("t2_release", {b_valid1, b_busy}, 0);
    b_taken1 = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
